wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- Writeback stage that sits directly upstream of the 8x16 register file and owns its single write port.
- Accepts writeback requests from two producers: the ALU path and the memory-return path.
- Orders the requests in a small FIFO and drains one entry per cycle onto writeregsel/writedata/write.
- Exports a pending-write mask so decode can interlock on registers whose writes are still queued.

Parameters:
- DW, 16, data width of a writeback.
- AW, 3, register select width (8 architectural registers).
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; low clears all state immediately.
- mem_valid  in  1  memory-return writeback request.
- mem_regsel  in  AW  destination register for the memory return.
- mem_data  in  DW  memory-return data.
- mem_ready  out  1  memory request accepted this cycle when mem_valid&&mem_ready.
- alu_valid  in  1  ALU writeback request.
- alu_regsel  in  AW  destination register for the ALU result.
- alu_data  in  DW  ALU result data.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid&&alu_ready.
- write  out  1  register-file write enable.
- writeregsel  out  AW  register-file write select.
- writedata  out  DW  register-file write data.
- pend_mask  out  2**AW  bit r=1 iff any queued entry targets register r.
- count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Storage: DEPTH entries of {regsel, data}; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH; count is a separate counter from 0 to DEPTH.
- Reset (rst low, asynchronous): wr_ptr=rd_ptr=0, count=0. Consequently write=0, writeregsel=0, writedata=0, pend_mask=0, mem_ready=1, alu_ready=1.
  - Entry contents need no reset.
  - Reset mid-operation discards all queued writes; none reach the register file.
- Drain (pop):
  - write=(count!=0).
  - writeregsel/writedata come combinationally from the head entry; they are 0 when empty.
  - pop = write. The head advances at the clock edge where the register file captures it.
- Space: space = (DEPTH - count) + pop.
  - mem_ready = (space >= 1).
  - alu_ready = (space >= (mem_valid ? 2 : 1)).
  - Both readies are combinational; neither depends on its own valid.
- Push ordering:
  - When both requests are accepted in the same cycle, the memory entry is written at wr_ptr and the ALU entry at wr_ptr+1. The memory return belongs to the older instruction, so this preserves write-after-write order.
  - A single accepted request is written at wr_ptr.
  - wr_ptr advances by the number of pushes (0, 1 or 2).
  - count_next = count + pushes - pop.
- Latency: a request accepted in cycle N appears on write/writeregsel/writedata in cycle N+1 if the queue was empty; otherwise behind the older entries. There is no same-cycle bypass.
- Full: count=DEPTH gives space=1, because pop=1 when full.
  - mem_ready=1.
  - alu_ready=!mem_valid: the ALU stalls only when the memory path takes the single slot.
- One free slot and both valid: memory accepted, ALU held off. The ALU must hold valid and payload stable until ready.
- Wrap-around: pointer overflow from DEPTH-1 to 0 is seamless; no entry is skipped or duplicated.
- pend_mask:
  - OR over all occupied entries of the one-hot decode of regsel.
  - Occupied means the slot index lies in [rd_ptr, rd_ptr+count) modulo DEPTH.
  - Derived from current state only; it does not include same-cycle incoming requests.
- Duplicate destinations: multiple queued entries may target the same register. All of them are written in FIFO order, so the last writer wins in the register file.

Decomposition:
- Shared package holds DW, AW, NREG (=8) and a writeback-request struct {regsel, data}, reused by the decode interlock logic.
- One natural sub-module: wb_fifo, a dual-push single-pop FIFO with pointers, count and entry array.
- wb_queue adds the ready logic, push ordering and pend_mask.

Test Plan:
- Reset, then single ALU push (alu_regsel=3, alu_data=16'hBEEF) in cycle N -> cycle N+1: write=1, writeregsel=3, writedata=16'hBEEF, pend_mask=8'h08. Cycle N+2: write=0, pend_mask=0.
- Simultaneous mem (reg 2, 16'h1111) and ALU (reg 2, 16'h2222) into an empty queue -> both accepted. Writes issue in two consecutive cycles: 16'h1111 then 16'h2222. Register file r2 ends at 16'h2222.
- Hold the register-file side busy with back-to-back dual pushes until count=4 -> mem_ready=1 and alu_ready=0 while mem_valid=1. Dropping mem_valid gives alu_ready=1. count never exceeds 4.
- Stream 10 single ALU pushes (regs 0..7,0,1; data=index) -> writes appear in order. Pointers wrap past index 3 without loss or duplication.
- Push 3 entries, assert rst low mid-cycle -> write, count and pend_mask go to 0 asynchronously. After release, no stale entry is ever written.
- With count=1 and both requests valid -> both accepted (space=4). count becomes 2 next cycle (1 + 2 - 1). pend_mask reflects both destinations.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// Shared writeback definitions: datapath widths and the writeback request record,
// also consumed by the decode interlock logic.
package wb_queue_pkg;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NREG  = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] regsel;
    logic [DW-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] sel);
    return {{(NREG-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop FIFO. Slot b is only written together with slot a, at the
// next pointer position, so two same-cycle pushes keep their relative order.
module wb_fifo #(
  parameter int  W     = 19,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a,
  input  logic [W-1:0]  data_a,
  input  logic          push_b,
  input  logic [W-1:0]  data_b,
  output logic          pop,
  output logic [W-1:0]  head,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic [W-1:0]  entries [DEPTH]
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] pushes_s;

  // Draining is unconditional: the register file always accepts the head.
  assign pop      = (count_r != {CW{1'b0}});
  assign pushes_s = CW'(push_a) + CW'(push_b);
  assign head     = mem_r[rd_ptr_r];
  assign rd_ptr   = rd_ptr_r;
  assign count    = count_r;
  assign entries  = mem_r;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PW'(pushes_s);
      rd_ptr_r <= rd_ptr_r + PW'(pop);
      count_r  <= count_r + pushes_s - CW'(pop);
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_a) begin
      mem_r[wr_ptr_r] <= data_a;
    end
    if (push_b) begin
      mem_r[wr_ptr_r + PW'(1'b1)] <= data_b;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue in front of the register-file write port: merges ALU and
// memory-return writebacks, drains one per cycle and exports a pending-write mask.
module wb_queue #(
  parameter int  DW    = wb_queue_pkg::DW,
  parameter int  AW    = wb_queue_pkg::AW,
  parameter int  DEPTH = wb_queue_pkg::DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1,
  localparam int NR    = 2 ** AW,
  localparam int W     = AW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_regsel,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_regsel,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  output logic          write,
  output logic [AW-1:0] writeregsel,
  output logic [DW-1:0] writedata,
  output logic [NR-1:0] pend_mask,
  output logic [CW-1:0] count
);

  import wb_queue_pkg::*;

  logic          pop_s;
  logic [W-1:0]  head_s;
  logic [PW-1:0] rd_ptr_s;
  logic [W-1:0]  entries_s [DEPTH];
  logic [CW-1:0] space_s;
  logic          mem_acc_s;
  logic          alu_acc_s;
  logic          push_a_s;
  logic          push_b_s;
  logic [W-1:0]  data_a_s;
  logic [PW-1:0] slot_off_s;

  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_a  (push_a_s),
    .data_a  (data_a_s),
    .push_b  (push_b_s),
    .data_b  ({alu_regsel, alu_data}),
    .pop     (pop_s),
    .head    (head_s),
    .rd_ptr  (rd_ptr_s),
    .count   (count),
    .entries (entries_s)
  );

  // The slot freed by this cycle's pop is reusable, so a full queue still takes one push.
  assign space_s = CW'(DEPTH) - count + CW'(pop_s);

  // Readies depend only on state and on the other producer's valid.
  always_comb begin
    mem_ready = (space_s >= CW'(1'b1));
    if (mem_valid) begin
      alu_ready = (space_s >= CW'(2'd2));
    end else begin
      alu_ready = (space_s >= CW'(1'b1));
    end
  end

  assign mem_acc_s = mem_valid && mem_ready;
  assign alu_acc_s = alu_valid && alu_ready;

  // Memory return is from the older instruction, so it takes the first slot.
  always_comb begin
    push_a_s = mem_acc_s || alu_acc_s;
    push_b_s = mem_acc_s && alu_acc_s;
    if (mem_acc_s) begin
      data_a_s = {mem_regsel, mem_data};
    end else begin
      data_a_s = {alu_regsel, alu_data};
    end
  end

  // Register-file port driven straight from the head entry.
  always_comb begin
    write = pop_s;
    if (pop_s) begin
      {writeregsel, writedata} = head_s;
    end else begin
      writeregsel = {AW{1'b0}};
      writedata   = {DW{1'b0}};
    end
  end

  // Pending mask: OR of destinations over slots in [rd_ptr, rd_ptr+count).
  always_comb begin
    pend_mask  = {NR{1'b0}};
    slot_off_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      slot_off_s = PW'(i) - rd_ptr_s;
      if ({1'b0, slot_off_s} < count) begin
        pend_mask = pend_mask | ({{(NR-1){1'b0}}, 1'b1} << entries_s[i][W-1 -: AW]);
      end else begin
        pend_mask = pend_mask;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with a small register-file model
// that records every write seen on the port.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [2:0]  mem_regsel, alu_regsel;
  logic [15:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [7:0]  pend_mask;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [18:0] wlog [$];
  logic [15:0] rf [8];

  wb_queue dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_regsel(mem_regsel), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_regsel(alu_regsel), .alu_data(alu_data), .alu_ready(alu_ready),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .pend_mask(pend_mask), .count(count)
  );

  always #5 clk = ~clk;

  // Register-file model: captures the port on each rising edge.
  always @(posedge clk) begin
    if (write === 1'b1) begin
      wlog.push_back({writeregsel, writedata});
      rf[writeregsel] <= writedata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    mem_regsel = 3'd0; mem_data = 16'h0000;
    alu_regsel = 3'd0; alu_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %0b want 0", write); end
    tests++; if (writeregsel !== 3'd0) begin fails++; $display("FAIL reset_regsel: got %0d want 0", writeregsel); end
    tests++; if (writedata !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", writedata); end
    tests++; if (pend_mask !== 8'h00) begin fails++; $display("FAIL reset_pend: got %h want 00", pend_mask); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL reset_mem_ready: got %0b want 1", mem_ready); end
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %0b want 1", alu_ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_regsel = 3'd3; alu_data = 16'hBEEF;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL single_alu_ready: got %0b want 1", alu_ready); end
    tick();
    idle();
    tests++; if (write !== 1'b1) begin fails++; $display("FAIL single_write: got %0b want 1", write); end
    tests++; if (writeregsel !== 3'd3) begin fails++; $display("FAIL single_regsel: got %0d want 3", writeregsel); end
    tests++; if (writedata !== 16'hBEEF) begin fails++; $display("FAIL single_data: got %h want beef", writedata); end
    tests++; if (pend_mask !== 8'h08) begin fails++; $display("FAIL single_pend: got %h want 08", pend_mask); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
    tick();
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL single_write_done: got %0b want 0", write); end
    tests++; if (pend_mask !== 8'h00) begin fails++; $display("FAIL single_pend_done: got %h want 00", pend_mask); end
  endtask

  task automatic test_dual_same_reg();
    mem_valid = 1'b1; mem_regsel = 3'd2; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_regsel = 3'd2; alu_data = 16'h2222;
    #1;
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL dual_mem_ready: got %0b want 1", mem_ready); end
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL dual_alu_ready: got %0b want 1", alu_ready); end
    tick();
    idle();
    tests++; if (writedata !== 16'h1111) begin fails++; $display("FAIL dual_first: got %h want 1111", writedata); end
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL dual_count: got %0d want 2", count); end
    tests++; if (pend_mask !== 8'h04) begin fails++; $display("FAIL dual_pend: got %h want 04", pend_mask); end
    tick();
    tests++; if (writedata !== 16'h2222) begin fails++; $display("FAIL dual_second: got %h want 2222", writedata); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL dual_count2: got %0d want 1", count); end
    tick();
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL dual_drained: got %0b want 0", write); end
    tests++; if (rf[2] !== 16'h2222) begin fails++; $display("FAIL dual_rf_r2: got %h want 2222", rf[2]); end
  endtask

  task automatic test_full();
    logic [15:0] exp_data [7];
    exp_data[0] = 16'hA000; exp_data[1] = 16'hB000; exp_data[2] = 16'hA001; exp_data[3] = 16'hB001;
    exp_data[4] = 16'hA002; exp_data[5] = 16'hB002; exp_data[6] = 16'hC000;
    wlog.delete();
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_regsel = 3'(k);     mem_data = 16'hA000 + 16'(k);
      alu_valid = 1'b1; alu_regsel = 3'(k + 4); alu_data = 16'hB000 + 16'(k);
      tick();
      tests++; if (count > 3'd4) begin fails++; $display("FAIL full_count_bound: got %0d want <=4", count); end
    end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", count); end
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL full_mem_ready: got %0b want 1", mem_ready); end
    tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL full_alu_stall: got %0b want 0", alu_ready); end
    mem_valid = 1'b0;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL full_alu_free: got %0b want 1", alu_ready); end
    alu_regsel = 3'd7; alu_data = 16'hC000;
    tick();
    idle();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count_hold: got %0d want 4", count); end
    repeat (4) tick();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL full_drain_count: got %0d want 0", count); end
    tests++; if (wlog.size() != 7) begin fails++; $display("FAIL full_log_size: got %0d want 7", wlog.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < wlog.size()) begin
        tests++;
        if (wlog[i][15:0] !== exp_data[i]) begin
          fails++; $display("FAIL full_order[%0d]: got %h want %h", i, wlog[i][15:0], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [18:0] e;
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_regsel = 3'(i % 8); alu_data = 16'(i);
      tick();
    end
    idle();
    repeat (2) tick();
    tests++; if (wlog.size() != 10) begin fails++; $display("FAIL stream_size: got %0d want 10", wlog.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < wlog.size()) begin
        e = {3'(i % 8), 16'(i)};
        tests++;
        if (wlog[i] !== e) begin fails++; $display("FAIL stream[%0d]: got %h want %h", i, wlog[i], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_regsel = 3'd1; mem_data = 16'h0101;
    alu_valid = 1'b1; alu_regsel = 3'd5; alu_data = 16'h0505;
    tick();
    mem_regsel = 3'd6; mem_data = 16'h0606;
    alu_regsel = 3'd7; alu_data = 16'h0707;
    tick();
    idle();
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL rstmid_count_pre: got %0d want 3", count); end
    tests++; if (pend_mask !== 8'hE0) begin fails++; $display("FAIL rstmid_pend_pre: got %h want e0", pend_mask); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL rstmid_write: got %0b want 0", write); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", count); end
    tests++; if (pend_mask !== 8'h00) begin fails++; $display("FAIL rstmid_pend: got %h want 00", pend_mask); end
    wlog.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (wlog.size() != 0) begin fails++; $display("FAIL rstmid_stale: got %0d writes want 0", wlog.size()); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rstmid_count_post: got %0d want 0", count); end
  endtask

  task automatic test_count_one();
    alu_valid = 1'b1; alu_regsel = 3'd3; alu_data = 16'h3333;
    tick();
    mem_valid = 1'b1; mem_regsel = 3'd4; mem_data = 16'h4444;
    alu_valid = 1'b1; alu_regsel = 3'd5; alu_data = 16'h5555;
    #1;
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL one_count_pre: got %0d want 1", count); end
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL one_alu_ready: got %0b want 1", alu_ready); end
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL one_mem_ready: got %0b want 1", mem_ready); end
    tick();
    idle();
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL one_count: got %0d want 2", count); end
    tests++; if (pend_mask !== 8'h30) begin fails++; $display("FAIL one_pend: got %h want 30", pend_mask); end
    tests++; if (writedata !== 16'h4444) begin fails++; $display("FAIL one_head: got %h want 4444", writedata); end
    tick();
    tests++; if (writedata !== 16'h5555) begin fails++; $display("FAIL one_next: got %h want 5555", writedata); end
    repeat (2) tick();
    tests++; if (rf[5] !== 16'h5555) begin fails++; $display("FAIL one_rf_r5: got %h want 5555", rf[5]); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual_same_reg();
    test_full();
    test_stream();
    test_reset_mid();
    test_count_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
